// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver: configurable payload width, parity, stop-bit
// count and oversampling ratio, with input synchroniser, false-start
// rejection and parity / framing / overrun error reporting.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   defined   -> every bit decision (start check, data, parity, stop) is a
//                2-of-3 vote of rx_s at ticks mid-1, mid, mid+1, taken at mid+1
//   undefined -> single sample at mid (start check at mid-1)
//
// Ports:
//   clk_50m     in   system clock
//   rst         in   asynchronous reset, active-high
//   clken       in   oversample tick, OVERSAMPLE ticks per bit
//   Rx          in   asynchronous serial input, idle high
//   rx_en       in   receiver enable; low aborts any frame in progress
//   ready_clr   in   host acknowledge; clears ready and all error flags
//   data        out  last received payload
//   ready       out  frame available (sticky until ready_clr)
//   parity_err  out  parity mismatch on the frame in data
//   frame_err   out  a stop bit sampled low on the frame in data
//   overrun     out  a frame completed while ready was still set (sticky)
//   busy        out  receiver FSM not idle
// -----------------------------------------------------------------------------
module uart_rx_param #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clk_50m,
    input  logic                 rst,
    input  logic                 clken,
    input  logic                 Rx,
    input  logic                 rx_en,
    input  logic                 ready_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned SW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = $clog2(DATA_BITS);
    localparam int unsigned MID = OVERSAMPLE / 2;

    localparam logic [SW-1:0] LAST_TICK  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST  = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic          ODD_PARITY = (PARITY_MODE == 2) ? 1'b1 : 1'b0;
    localparam logic          HAS_PARITY = (PARITY_MODE != 0) ? 1'b1 : 1'b0;

`ifdef UART_RX_MAJORITY_EN
    // Vote completes once the mid+1 sample is available.
    localparam logic [SW-1:0] DEC_TICK   = SW'(MID + 1);
    localparam logic [SW-1:0] START_TICK = SW'(MID + 1);
`else
    // Start validity is checked one tick early so a glitch is dropped before mid.
    localparam logic [SW-1:0] DEC_TICK   = SW'(MID);
    localparam logic [SW-1:0] START_TICK = SW'(MID - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // 2-of-3 majority vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // True when payload plus received parity bit disagree with the configured sense
    function automatic logic parity_fail(input logic [DATA_BITS-1:0] payload,
                                         input logic pbit, input logic odd);
        return ((^payload) ^ pbit) != odd;
    endfunction

    logic [1:0]           sync_q, sync_d;
    state_t               state_q, state_d;
    logic [SW-1:0]        sample_q, sample_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] scratch_q, scratch_d;
    logic                 armed_q, armed_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;
    logic                 rx_s;
    logic                 bit_s;
    logic                 complete_s;

    // Two-flop synchroniser on the asynchronous Rx pin
    always_comb begin
        sync_d = {sync_q[0], Rx};
    end

    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q, hist_d;

    // History of the two previous active-tick samples feeding the vote
    always_comb begin
        if (clken && rx_en) begin
            hist_d = {hist_q[0], rx_s};
        end else begin
            hist_d = hist_q;
        end
    end

    // Majority history register
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end

    // Bit decision from the vote of ticks mid-1, mid and mid+1
    always_comb begin
        bit_s = maj3(hist_q[1], hist_q[0], rx_s);
    end
`else
    // Bit decision from a single sample
    always_comb begin
        bit_s = rx_s;
    end
`endif

    // Receive FSM next-state and frame-scratch logic
    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        scratch_d  = scratch_q;
        armed_d    = armed_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        complete_s = 1'b0;

        if (!rx_en) begin
            // Disable aborts at once; disarm so a low line cannot start a frame.
            state_d    = ST_IDLE;
            sample_d   = '0;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            scratch_d  = '0;
            armed_d    = 1'b0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
        end else if (clken) begin
            case (state_q)
                ST_IDLE: begin
                    // Only a high-to-low edge seen after an armed high starts a frame.
                    if (armed_q && !rx_s) begin
                        state_d    = ST_START;
                        sample_d   = SW'(1);
                        bit_cnt_d  = '0;
                        stop_cnt_d = 1'b0;
                        scratch_d  = '0;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                    end else if (rx_s) begin
                        armed_d = 1'b1;
                    end else begin
                        armed_d = armed_q;
                    end
                end
                ST_START: begin
                    if ((sample_q == START_TICK) && bit_s) begin
                        state_d  = ST_IDLE;
                        sample_d = '0;
                    end else if (sample_q == LAST_TICK) begin
                        state_d   = ST_DATA;
                        sample_d  = '0;
                        bit_cnt_d = '0;
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (sample_q == DEC_TICK) begin
                        scratch_d[bit_cnt_q] = bit_s;
                    end else begin
                        scratch_d = scratch_q;
                    end
                    if (sample_q == LAST_TICK) begin
                        sample_d = '0;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d  = '0;
                            stop_cnt_d = 1'b0;
                            state_d    = HAS_PARITY ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (sample_q == DEC_TICK) begin
                        perr_d = parity_fail(scratch_q, bit_s, ODD_PARITY);
                    end else begin
                        perr_d = perr_q;
                    end
                    if (sample_q == LAST_TICK) begin
                        state_d    = ST_STOP;
                        sample_d   = '0;
                        stop_cnt_d = 1'b0;
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (sample_q == DEC_TICK) begin
                        ferr_d = ferr_q | ~bit_s;
                        // Complete at mid of the last stop bit so back-to-back frames fit.
                        if (stop_cnt_q == STOP_LAST) begin
                            complete_s = 1'b1;
                            state_d    = ST_IDLE;
                            sample_d   = '0;
                            stop_cnt_d = 1'b0;
                            armed_d    = rx_s;
                        end else begin
                            sample_d = sample_q + 1'b1;
                        end
                    end else if (sample_q == LAST_TICK) begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                        sample_d   = '0;
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    sample_d   = '0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    scratch_d  = '0;
                    armed_d    = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Host-visible outputs: completion sets, ready_clr clears, set wins on collision
    always_comb begin
        data_d       = data_q;
        ready_d      = ready_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;

        if (ready_clr) begin
            ready_d      = 1'b0;
            parity_err_d = 1'b0;
            frame_err_d  = 1'b0;
            overrun_d    = 1'b0;
        end else begin
            ready_d = ready_q;
        end

        if (complete_s) begin
            data_d       = scratch_q;
            ready_d      = 1'b1;
            parity_err_d = perr_q;
            frame_err_d  = ferr_d;
            overrun_d    = overrun_d | (ready_q & ~ready_clr);
        end else begin
            data_d = data_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters, synchroniser and output registers
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            sync_q       <= 2'b11;
            state_q      <= ST_IDLE;
            sample_q     <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            scratch_q    <= '0;
            armed_q      <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            data_q       <= '0;
            ready_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            sample_q     <= sample_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            scratch_q    <= scratch_d;
            armed_q      <= armed_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            data_q       <= data_d;
            ready_q      <= ready_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign data       = data_q;
    assign ready      = ready_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule
